// File: rtl/glb_stream_arbiter.sv
// rtl/glb_stream_arbiter.sv - round-robin, stream-locked merge of NUM_IN token streams onto one GLB channel
// Optional per-input accepted-token counters are built when GLB_ARB_STATS_EN is defined.
module glb_stream_arbiter #(
   parameter int                NUM_IN     = 2,
   parameter int                DATA_W     = 17,
   parameter int                TX_NUM     = 1,
   parameter logic [DATA_W-1:0] DONE_TOKEN = DATA_W'(17'h10100),
   parameter int                ID_W       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   input  logic [NUM_IN-1:0]    in_valid,
   output logic [NUM_IN-1:0]    in_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_IN*16-1:0] stat_tokens
);

   localparam int CNT_W = $clog2(TX_NUM + 1);

   typedef enum logic [1:0] {IDLE, LOCK, DRAIN, DONE} state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [NUM_IN-1:0]   finished;
   logic [CNT_W-1:0]    done_cnt [NUM_IN];
   logic [NUM_IN-1:0]   grant_sel;
   logic [NUM_IN-1:0]   eligible;
   logic [2*NUM_IN-1:0] elig_rot;
   logic [DATA_W-1:0]   owner_tok;
   logic                out_free, take, take_done;
   logic                pick_found;
   logic [ID_W-1:0]     pick_id;
   logic [ID_W-1:0]     rr_next;

   always_comb begin
      owner_tok = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         grant_sel[i] = (grant_id == ID_W'(i));
         if (grant_sel[i]) owner_tok = in_data[i*DATA_W +: DATA_W];
      end
   end

   assign out_free  = !out_valid || out_ready;
   assign in_ready  = grant_sel & {NUM_IN{(state == LOCK) && out_free}};
   assign take      = |(in_valid & in_ready);
   assign take_done = take && (owner_tok == DONE_TOKEN);
   assign busy      = (state == LOCK);
   assign done      = (state == DONE);
   assign rr_next   = (grant_id == ID_W'(NUM_IN - 1)) ? '0 : grant_id + 1'b1;

   // Rotate the eligible mask so that bit 0 is rr_ptr; the lowest set bit wins.
   assign eligible = in_valid & ~finished;
   assign elig_rot = {eligible, eligible} >> rr_ptr;

   always_comb begin
      int sum;
      sum        = 0;
      pick_found = 1'b0;
      pick_id    = '0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         if (elig_rot[k]) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_IN) sum = sum - NUM_IN;
            pick_found = 1'b1;
            pick_id    = ID_W'(sum);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (pick_found) state_nxt = LOCK;
                else if (&finished) state_nxt = DRAIN;
         LOCK:  if (take_done) state_nxt = IDLE;
         DRAIN: if (out_free) state_nxt = DONE;
         DONE:  state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant_id  <= '0;
         rr_ptr    <= '0;
         finished  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         for (int i = 0; i < NUM_IN; i++) done_cnt[i] <= '0;
      end else if (flush) begin
         state     <= IDLE;
         grant_id  <= '0;
         rr_ptr    <= '0;
         finished  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         for (int i = 0; i < NUM_IN; i++) done_cnt[i] <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_found) grant_id <= pick_id;
         if (take) begin
            out_data  <= owner_tok;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (take_done) begin
            rr_ptr <= rr_next;
            for (int i = 0; i < NUM_IN; i++) begin
               if (grant_sel[i]) begin
                  done_cnt[i] <= done_cnt[i] + 1'b1;
                  if (done_cnt[i] == CNT_W'(TX_NUM - 1)) finished[i] <= 1'b1;
               end
            end
         end
      end
   end

`ifdef GLB_ARB_STATS_EN
   logic [15:0] stat_cnt [NUM_IN];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_IN; i++) stat_cnt[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_IN; i++) stat_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_IN; i++)
            if (in_valid[i] && in_ready[i] && stat_cnt[i] != 16'hFFFF)
               stat_cnt[i] <= stat_cnt[i] + 16'd1;
      end
   end

   for (genvar g = 0; g < NUM_IN; g++) begin : g_stat
      assign stat_tokens[g*16 +: 16] = stat_cnt[g];
   end
`else
   assign stat_tokens = '0;
`endif

endmodule

// File: tb/tb_glb_stream_arbiter.sv
// tb/tb_glb_stream_arbiter.sv - self-checking bench for glb_stream_arbiter
// Covers TX_NUM=1 and TX_NUM=2 instances driven from shared stimulus.
module tb_glb_stream_arbiter;

   localparam logic [16:0] DT = 17'h10100;

   logic        clk, rst, flush, out_ready, sel;
   logic [33:0] in_data;
   logic [1:0]  in_valid;

   logic [1:0]  ir1, ir2;
   logic [16:0] od1, od2;
   logic        ov1, ov2, gid1, gid2, busy1, busy2, done1, done2;
   logic [31:0] st1, st2;

   logic [1:0]  o_ready;
   logic [16:0] o_data;
   logic        o_valid, o_grant, o_busy, o_done;

   glb_stream_arbiter #(.NUM_IN(2), .DATA_W(17), .TX_NUM(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
      .grant_id(gid1), .busy(busy1), .done(done1), .stat_tokens(st1));

   glb_stream_arbiter #(.NUM_IN(2), .DATA_W(17), .TX_NUM(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
      .grant_id(gid2), .busy(busy2), .done(done2), .stat_tokens(st2));

   assign o_ready = sel ? ir2   : ir1;
   assign o_data  = sel ? od2   : od1;
   assign o_valid = sel ? ov2   : ov1;
   assign o_grant = sel ? gid2  : gid1;
   assign o_busy  = sel ? busy2 : busy1;
   assign o_done  = sel ? done2 : done1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [16:0] src0[$], src1[$], exp_q[$];
   int          grant_log[$];
   logic        prev_busy, stall_pending;
   logic [16:0] stall_data;

   typedef struct packed {
      logic [1:0]  v;
      logic [16:0] d0;
      logic [16:0] d1;
      logic        ordy;
      logic        ov;
      logic [16:0] od;
      logic        chk_od;
      logic        busy;
      logic        gid;
      logic        done;
      logic [1:0]  ir;
   } row_t;

   row_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
      src0.delete(); src1.delete(); exp_q.delete(); grant_log.delete();
      prev_busy = 1'b0; stall_pending = 1'b0; stall_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One cycle of stimulus; scoreboard pops on every output transfer.
   task automatic step(input logic ordy, input logic [1:0] hold, input logic fl);
      logic [16:0] e;
      @(negedge clk);
      out_ready = ordy;
      flush     = fl;
      in_valid[0]     = (src0.size() > 0) && !hold[0];
      in_data[16:0]   = (src0.size() > 0) ? src0[0] : 17'h0;
      in_valid[1]     = (src1.size() > 0) && !hold[1];
      in_data[33:17]  = (src1.size() > 0) ? src1[0] : 17'h0;
      #1;
      if (stall_pending) begin
         check("bp_valid_hold", 32'(o_valid), 32'd1);
         check("bp_data_hold", 32'(o_data), 32'(stall_data));
      end
      stall_pending = o_valid && !ordy;
      stall_data    = o_data;
      if (o_valid && ordy) begin
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL extra_output: got %h, required no output", o_data);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", 32'(o_data), 32'(e));
         end
      end
      if (o_busy && !prev_busy) grant_log.push_back(int'(o_grant));
      prev_busy = o_busy;
      if (in_valid[0] && o_ready[0]) void'(src0.pop_front());
      if (in_valid[1] && o_ready[1]) void'(src1.pop_front());
   endtask

   task automatic drain(input logic bp);
      int  c;
      logic ordy;
      c = 0;
      while (exp_q.size() > 0 && c < 400) begin
         ordy = (bp && (c % 4 == 1 || c % 4 == 2)) ? 1'b0 : 1'b1;
         check("done_early", 32'(o_done), 32'd0);
         step(ordy, 2'b00, 1'b0);
         c++;
      end
      check("drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_done();
      for (int c = 0; c < 6 && !o_done; c++) step(1'b1, 2'b00, 1'b0);
      check("done_set", 32'(o_done), 32'd1);
   endtask

   task automatic check_grants(input string name, input int n, input int first);
      check({name, "_count"}, 32'(grant_log.size()), 32'(n));
      for (int i = 0; i < n && i < grant_log.size(); i++)
         check({name, "_order"}, 32'(grant_log[i]), 32'((first + i) % 2));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_stat;
      sel = 1'b0;

      // {v, d0, d1, ordy, ov, od, chk_od, busy, gid, done, ir}
      tbl[0] = {2'b11, 17'h00001, 17'h00003, 1'b1, 1'b0, 17'h0,     1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
      tbl[1] = {2'b11, 17'h00001, 17'h00003, 1'b1, 1'b1, 17'h00001, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
      tbl[2] = {2'b11, 17'h00002, 17'h00003, 1'b1, 1'b1, 17'h00002, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
      tbl[3] = {2'b11, DT,        17'h00003, 1'b1, 1'b1, DT,        1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      tbl[4] = {2'b11, 17'h0000F, 17'h00003, 1'b1, 1'b0, 17'h0,     1'b0, 1'b1, 1'b1, 1'b0, 2'b10};
      tbl[5] = {2'b11, 17'h0000F, 17'h00003, 1'b1, 1'b1, 17'h00003, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10};
      tbl[6] = {2'b11, 17'h0000F, DT,        1'b1, 1'b1, DT,        1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
      tbl[7] = {2'b11, 17'h0000F, 17'h0000F, 1'b1, 1'b0, 17'h0,     1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      tbl[8] = {2'b11, 17'h0000F, 17'h0000F, 1'b1, 1'b0, 17'h0,     1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
      tbl[9] = {2'b11, 17'h0000F, 17'h0000F, 1'b1, 1'b0, 17'h0,     1'b0, 1'b0, 1'b1, 1'b1, 2'b00};

      // Reset state, sampled while rst is held with upstream offering tokens.
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 2'b11; in_data = {17'h3, 17'h1};
      @(posedge clk); #1;
      check("rst_out_valid", 32'(ov1), 32'd0);
      check("rst_out_data", 32'(od1), 32'd0);
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_grant", 32'(gid1), 32'd0);
      check("rst_done", 32'(done1), 32'd0);
      check("rst_in_ready", 32'(ir1), 32'd0);
      check("rst_stat", st1, 32'd0);
      check("rst_done2", 32'(done2), 32'd0);

      // Scenario 1: cycle-exact table
      do_reset();
      for (int r = 0; r < 10; r++) begin
         @(negedge clk);
         in_valid  = tbl[r].v;
         in_data   = {tbl[r].d1, tbl[r].d0};
         out_ready = tbl[r].ordy;
         @(posedge clk); #1;
         check($sformatf("t%0d_out_valid", r), 32'(ov1), 32'(tbl[r].ov));
         if (tbl[r].chk_od) check($sformatf("t%0d_out_data", r), 32'(od1), 32'(tbl[r].od));
         check($sformatf("t%0d_busy", r), 32'(busy1), 32'(tbl[r].busy));
         check($sformatf("t%0d_grant", r), 32'(gid1), 32'(tbl[r].gid));
         check($sformatf("t%0d_done", r), 32'(done1), 32'(tbl[r].done));
         check($sformatf("t%0d_in_ready", r), 32'(ir1), 32'(tbl[r].ir));
      end
`ifdef GLB_ARB_STATS_EN
      exp_stat = {16'd2, 16'd3};
`else
      exp_stat = 32'd0;
`endif
      check("stat_tokens", st1, exp_stat);

      // Scenario 2: owner stalls mid-stream
      do_reset();
      src0 = '{17'h11, 17'h12, 17'h13, DT};
      src1 = '{17'h21, DT};
      exp_q = '{17'h11, 17'h12, 17'h13, DT, 17'h21, DT};
      repeat (3) step(1'b1, 2'b00, 1'b0);
      for (int c = 0; c < 5; c++) begin
         step(1'b1, 2'b01, 1'b0);
         check("stall_ready1", 32'(o_ready[1]), 32'd0);
         check("stall_busy", 32'(o_busy), 32'd1);
         check("stall_grant", 32'(o_grant), 32'd0);
      end
      drain(1'b0);
      wait_done();
      check_grants("stall_grants", 2, 0);

      // Scenario 3: backpressure 1,0,0,1
      do_reset();
      src0 = '{17'h31, 17'h32, 17'h33, DT};
      src1 = '{17'h41, 17'h42, DT};
      exp_q = '{17'h31, 17'h32, 17'h33, DT, 17'h41, 17'h42, DT};
      drain(1'b1);
      wait_done();

      // Scenario 4: TX_NUM=2, two streams per input
      sel = 1'b1;
      do_reset();
      src0 = '{17'h51, DT, 17'h52, DT};
      src1 = '{17'h61, DT, 17'h62, DT};
      exp_q = '{17'h51, DT, 17'h61, DT, 17'h52, DT, 17'h62, DT};
      drain(1'b0);
      wait_done();
      check_grants("tx2_grants", 4, 0);
      sel = 1'b0;

      // Scenario 5: flush while input 1 owns the channel (rr_ptr is 1)
      do_reset();
      src0 = '{17'h71, DT};
      src1 = '{17'h81, 17'h82, 17'h83, DT};
      exp_q = '{17'h71, DT, 17'h81, 17'h82};
      repeat (6) step(1'b1, 2'b00, 1'b0);
      step(1'b1, 2'b00, 1'b1);
      check("pre_flush_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      check("flush_out_valid", 32'(o_valid), 32'd0);
      check("flush_busy", 32'(o_busy), 32'd0);
      check("flush_done", 32'(o_done), 32'd0);
      check("flush_grant", 32'(o_grant), 32'd0);
      check("flush_stat", st1, 32'd0);
      src0.delete(); src1.delete(); grant_log.delete(); prev_busy = 1'b0;
      src0 = '{17'h91, DT};
      src1 = '{17'hA1, DT};
      exp_q = '{17'h91, DT, 17'hA1, DT};
      drain(1'b0);
      wait_done();
      check_grants("flush_grants", 2, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
